// File: rtl/billiard_pkg.sv
// Types and helpers shared by the billiard drawing/game-control blocks.
package billiard_pkg;

  localparam int NUM_HOLES = 6;

  // Hole number 1..NUM_HOLES, 0 means "no hole".
  typedef logic [2:0] hole_idx_t;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    REPORT   = 2'd1,
    COOLDOWN = 2'd2
  } pocket_state_t;

  // Lowest-numbered qualifying hole wins; returns 0 when none qualifies.
  function automatic hole_idx_t first_qualifier(input logic [NUM_HOLES-1:0] ge);
    hole_idx_t w;
    w = 3'd0;
    for (int i = NUM_HOLES - 1; i >= 0; i--) begin
      w = ge[i] ? hole_idx_t'(i + 1) : w;
    end
    return w;
  endfunction

endpackage

// File: rtl/overlap_counter.sv
// Saturating per-frame ball/hole overlap counter with a registered threshold flag.
module overlap_counter #(
  parameter int CNT_W     = 10,
  parameter int THRESHOLD = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic ge_threshold_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ge_q;

  // A clear starts a new frame, seeded with this pixel's overlap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = inc_i ? CNT_ONE : {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count and flag registers; the flag always tracks the stored count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
      ge_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ge_q  <= (cnt_d >= THR);
    end
  end

  assign ge_threshold_o = ge_q;

endmodule

// File: rtl/hole_pocket_detector.sv
// Decides which hole the ball dropped into from per-frame overlap counts and
// hands the hole number to game control with a valid/ack handshake.
module hole_pocket_detector
  import billiard_pkg::*;
#(
  parameter int OVERLAP_THRESHOLD = 64,
  parameter int CONFIRM_FRAMES    = 2,
  parameter int COOLDOWN_FRAMES   = 30,
  parameter int CNT_W             = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       drawingRequestBall,
  input  logic [5:0] drawingRequestHoles,
  input  logic       pocketAck,
  output logic       pocketValid,
  output logic [2:0] holeNumber,
  output logic [1:0] state_dbg
);

  localparam int CONF_W = (CONFIRM_FRAMES < 1) ? 1 : $clog2(CONFIRM_FRAMES + 1);
  localparam int COOL_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [CONF_W-1:0] CONF_ONE   = {{(CONF_W-1){1'b0}}, 1'b1};
  localparam logic [CONF_W-1:0] CONF_LIMIT = CONF_W'(CONFIRM_FRAMES);
  localparam logic [COOL_W-1:0] COOL_ONE   = {{(COOL_W-1){1'b0}}, 1'b1};
  localparam logic [COOL_W-1:0] COOL_INIT  = COOL_W'(COOLDOWN_FRAMES);

  logic [NUM_HOLES-1:0] ge_s;
  hole_idx_t            winner_s;

  pocket_state_t        state_q, state_d;
  hole_idx_t            cand_q, cand_d;
  logic [CONF_W-1:0]    conf_q, conf_d;
  logic [COOL_W-1:0]    cool_q, cool_d;
  logic                 valid_q, valid_d;
  hole_idx_t            hole_q, hole_d;

  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_cnt
    overlap_counter #(
      .CNT_W     (CNT_W),
      .THRESHOLD (OVERLAP_THRESHOLD)
    ) u_cnt (
      .clk_i          (clk),
      .rst_ni         (resetN),
      .clear_i        (startOfFrame),
      .inc_i          (drawingRequestBall & drawingRequestHoles[g]),
      .ge_threshold_o (ge_s[g])
    );
  end

  // ge_s reflects the frame that ends at this startOfFrame pulse.
  assign winner_s = first_qualifier(ge_s);

  // Pocket FSM: confirm over frames, report, then hold off for a cooldown.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    conf_d  = conf_q;
    cool_d  = cool_q;
    valid_d = valid_q;
    hole_d  = hole_q;
    case (state_q)
      SCAN: begin
        if (startOfFrame) begin
          if (winner_s == 3'd0) begin
            cand_d = 3'd0;
            conf_d = {CONF_W{1'b0}};
          end else if (winner_s == cand_q) begin
            conf_d = conf_q + CONF_ONE;
          end else begin
            cand_d = winner_s;
            conf_d = CONF_ONE;
          end
          if ((winner_s != 3'd0) && (conf_d >= CONF_LIMIT)) begin
            state_d = REPORT;
            valid_d = 1'b1;
            hole_d  = cand_d;
          end else begin
            state_d = SCAN;
          end
        end else begin
          state_d = SCAN;
        end
      end
      REPORT: begin
        // Ack takes priority over a coincident frame start.
        if (pocketAck) begin
          state_d = COOLDOWN;
          valid_d = 1'b0;
          hole_d  = 3'd0;
          cool_d  = COOL_INIT;
        end else begin
          state_d = REPORT;
        end
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          if (cool_q <= COOL_ONE) begin
            state_d = SCAN;
            cool_d  = {COOL_W{1'b0}};
            cand_d  = 3'd0;
            conf_d  = {CONF_W{1'b0}};
          end else begin
            cool_d  = cool_q - COOL_ONE;
          end
        end else begin
          state_d = COOLDOWN;
        end
      end
      default: begin
        state_d = SCAN;
        cand_d  = 3'd0;
        conf_d  = {CONF_W{1'b0}};
        cool_d  = {COOL_W{1'b0}};
        valid_d = 1'b0;
        hole_d  = 3'd0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= SCAN;
      cand_q  <= 3'd0;
      conf_q  <= {CONF_W{1'b0}};
      cool_q  <= {COOL_W{1'b0}};
      valid_q <= 1'b0;
      hole_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      conf_q  <= conf_d;
      cool_q  <= cool_d;
      valid_q <= valid_d;
      hole_q  <= hole_d;
    end
  end

  assign pocketValid = valid_q;
  assign holeNumber  = hole_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_hole_pocket_detector.sv
// Directed bench for hole_pocket_detector with hand-computed expectations.
module tb_hole_pocket_detector;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       drawingRequestBall = 1'b0;
  logic [5:0] drawingRequestHoles = 6'd0;
  logic       pocketAck = 1'b0;
  logic       pocketValid;
  logic [2:0] holeNumber;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  hole_pocket_detector dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .drawingRequestBall  (drawingRequestBall),
    .drawingRequestHoles (drawingRequestHoles),
    .pocketAck           (pocketAck),
    .pocketValid         (pocketValid),
    .holeNumber          (holeNumber),
    .state_dbg           (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic px(input logic [5:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      drawingRequestBall  = 1'b1;
      drawingRequestHoles = mask;
      @(negedge clk);
    end
    drawingRequestBall  = 1'b0;
    drawingRequestHoles = 6'd0;
  endtask

  task automatic sof(input logic [5:0] mask);
    startOfFrame        = 1'b1;
    drawingRequestBall  = (mask != 6'd0);
    drawingRequestHoles = mask;
    @(negedge clk);
    startOfFrame        = 1'b0;
    drawingRequestBall  = 1'b0;
    drawingRequestHoles = 6'd0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic ack_pulse();
    pocketAck = 1'b1;
    @(negedge clk);
    pocketAck = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid", 8'(pocketValid), 8'd0);
    check("rst_hole", 8'(holeNumber), 8'd0);
    check("rst_state", 8'(state_dbg), 8'd0);
    resetN = 1'b1;

    // Hole 3, 100 px in two frames; stray ack in SCAN is ignored
    sof(6'd0);
    px(6'b000100, 100);
    sof(6'd0);
    ack_pulse();
    px(6'b000100, 100);
    check("h3_pre_valid", 8'(pocketValid), 8'd0);
    sof(6'd0);
    check("h3_valid", 8'(pocketValid), 8'd1);
    check("h3_hole", 8'(holeNumber), 8'd3);
    check("h3_state", 8'(state_dbg), 8'd1);
    repeat (50) @(negedge clk);
    check("h3_hold_valid", 8'(pocketValid), 8'd1);
    check("h3_hold_hole", 8'(holeNumber), 8'd3);
    px(6'b010000, 70);
    sof(6'd0);
    check("h3_ignore_frame", 8'(holeNumber), 8'd3);
    ack_pulse();
    check("h3_ack_valid", 8'(pocketValid), 8'd0);
    check("h3_ack_hole", 8'(holeNumber), 8'd0);
    check("h3_ack_state", 8'(state_dbg), 8'd2);

    // Cooldown of 30 frames with hole 1 qualifying throughout
    for (int k = 1; k <= 29; k++) begin
      px(6'b000001, 70);
      sof(6'd0);
      check("cd_stays", 8'({state_dbg, pocketValid}), 8'd4);
    end
    px(6'b000001, 70);
    sof(6'd0);
    check("cd_exit_state", 8'(state_dbg), 8'd0);
    px(6'b000001, 70);
    sof(6'd0);
    check("cd_first_frame", 8'(pocketValid), 8'd0);
    px(6'b000001, 70);
    sof(6'd0);
    check("cd_report_valid", 8'(pocketValid), 8'd1);
    check("cd_report_hole", 8'(holeNumber), 8'd1);

    // Ack together with startOfFrame: cooldown still a full 30 frames
    px(6'b000001, 70);
    pocketAck    = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    pocketAck    = 1'b0;
    startOfFrame = 1'b0;
    check("coinc_state", 8'(state_dbg), 8'd2);
    check("coinc_valid", 8'(pocketValid), 8'd0);
    for (int k = 1; k <= 29; k++) begin
      px(6'b000001, 70);
      sof(6'd0);
    end
    check("coinc_29", 8'(state_dbg), 8'd2);
    px(6'b000001, 70);
    sof(6'd0);
    check("coinc_30", 8'(state_dbg), 8'd0);

    // 63 px never qualifies; 64 px does (SOF pixel counts into the new frame)
    do_reset();
    sof(6'd0);
    for (int k = 0; k < 5; k++) begin
      px(6'b000001, 63);
      sof(6'd0);
      check("t63_no_valid", 8'({state_dbg, pocketValid}), 8'd0);
    end
    px(6'b000001, 64);
    sof(6'b000001);
    check("t64_first", 8'(pocketValid), 8'd0);
    px(6'b000001, 63);
    sof(6'd0);
    check("t64_valid", 8'(pocketValid), 8'd1);
    check("t64_hole", 8'(holeNumber), 8'd1);

    // Holes 2 and 5 tie: lowest wins; ack on first valid cycle
    do_reset();
    sof(6'd0);
    px(6'b010010, 80);
    sof(6'd0);
    check("tie_first", 8'(pocketValid), 8'd0);
    px(6'b010010, 80);
    sof(6'd0);
    check("tie_valid", 8'(pocketValid), 8'd1);
    check("tie_hole", 8'(holeNumber), 8'd2);
    ack_pulse();
    check("tie_fast_ack_valid", 8'(pocketValid), 8'd0);
    check("tie_fast_ack_state", 8'(state_dbg), 8'd2);

    // Alternating hole 4 / hole 6 never confirms
    do_reset();
    sof(6'd0);
    for (int k = 0; k < 6; k++) begin
      px(((k % 2) == 0) ? 6'b001000 : 6'b100000, 70);
      sof(6'd0);
      check("alt_no_valid", 8'(pocketValid), 8'd0);
    end

    // Saturation: 2078 px would wrap to 30 in a 10-bit counter
    do_reset();
    sof(6'd0);
    px(6'b000100, 2000);
    sof(6'd0);
    check("sat_first", 8'(pocketValid), 8'd0);
    px(6'b000100, 2078);
    sof(6'd0);
    check("sat_valid", 8'(pocketValid), 8'd1);
    check("sat_hole", 8'(holeNumber), 8'd3);

    // Asynchronous reset while reporting hole 4
    do_reset();
    sof(6'd0);
    px(6'b001000, 70);
    sof(6'd0);
    px(6'b001000, 70);
    sof(6'd0);
    check("ar_hole_before", 8'(holeNumber), 8'd4);
    #2 resetN = 1'b0;
    #1;
    check("ar_valid", 8'(pocketValid), 8'd0);
    check("ar_hole", 8'(holeNumber), 8'd0);
    check("ar_state", 8'(state_dbg), 8'd0);
    @(negedge clk);
    resetN = 1'b1;
    px(6'b001000, 70);
    sof(6'd0);
    check("ar_restart", 8'(pocketValid), 8'd0);
    px(6'b001000, 70);
    sof(6'd0);
    check("ar_report_hole", 8'(holeNumber), 8'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
